// File: rtl/theta_accum_pkg.sv
// Shared constants and helpers for the phase-angle accumulator.
// Angles are held internally as signed Q4.28; the I/O format is IEEE single.
package theta_accum_pkg;

    localparam int SINGLE = 32;
    localparam int FRAC   = 28;

    typedef logic [SINGLE-1:0] single_t;

    localparam logic signed [31:0] TWO_PI_FIX = 32'sh6487ED51;
    localparam logic signed [31:0] SAT_FIX    = 32'sh1FFFFFFF;

    // A single correction is enough because every increment magnitude is below 2*pi.
    function automatic logic signed [31:0] wrap_angle(input logic signed [31:0] s);
        logic signed [31:0] r;
        if (s >= TWO_PI_FIX) begin
            r = s - TWO_PI_FIX;
        end else if (s < 0) begin
            r = s + TWO_PI_FIX;
        end else begin
            r = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/theta_accum_if.sv
// Step-request / angle-result bundle between the electrical model and theta_accum.
interface theta_accum_if;
    import theta_accum_pkg::*;

    logic    sta;
    logic    clr;
    single_t dtheta;
    single_t theta;
    logic    done_sig;
    logic    ovf;

    modport master (output sta, clr, dtheta, input theta, done_sig, ovf);
    modport slave  (input sta, clr, dtheta, output theta, done_sig, ovf);

endinterface

// File: rtl/theta_accum_fix_to_single.sv
// Combinational normalizer: unsigned Q4.28 angle in [0, 2*pi) to IEEE single,
// mantissa truncated toward zero.
module fix_to_single
    import theta_accum_pkg::*;
(
    input  logic [31:0] fix_i,
    output single_t     single_o
);

    logic [4:0]  lead;
    logic [31:0] norm;
    logic [7:0]  expo;

    always_comb begin
        lead = '0;
        for (int i = 0; i < 31; i++) begin
            if (fix_i[i]) begin
                lead = 5'(i);
            end
        end
        // Leading one lands on bit 31, so the 23 bits below it are norm[30:8].
        norm     = fix_i << (5'd31 - lead);
        expo     = 8'(lead) + 8'(127 - FRAC);
        single_o = '0;
        if (fix_i != '0) begin
            single_o = {1'b0, expo, norm[30:8]};
        end
    end

endmodule

// File: rtl/theta_accum.sv
// Three-stage phase integrator: float->fixed, accumulate with wrap to [0, 2*pi),
// fixed->float. One step per cycle, no backpressure.
module theta_accum
    import theta_accum_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    theta_accum_if.slave bus
);

    logic               v1_q, v2_q, done_q, ovf_q;
    logic signed [31:0] d1_q, acc_q;
    single_t            theta_q;

    logic signed [31:0] d1_d, acc_d;
    logic               sat_d, ovf_d;
    single_t            theta_d;

    logic [7:0]  exp_in;
    logic [31:0] mant;
    logic [31:0] mag;

    always_comb begin
        exp_in = bus.dtheta[30:23];
        mant   = {8'h00, 1'b1, bus.dtheta[22:0]};
        mag    = '0;
        sat_d  = 1'b0;
        d1_d   = '0;
        if (exp_in == 8'hFF) begin
            sat_d = 1'b1;
            d1_d  = SAT_FIX;
        end else if (exp_in >= 8'd128) begin
            sat_d = 1'b1;
            d1_d  = bus.dtheta[31] ? -SAT_FIX : SAT_FIX;
        end else if (exp_in >= 8'd98) begin
            // Exponent 122 is the point where the mantissa already sits at Q4.28.
            if (exp_in >= 8'd122) begin
                mag = mant << (exp_in - 8'd122);
            end else begin
                mag = mant >> (8'd122 - exp_in);
            end
            d1_d = bus.dtheta[31] ? -$signed(mag) : $signed(mag);
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (bus.clr) begin
            acc_d = v1_q ? wrap_angle(d1_q) : '0;
        end else if (v1_q) begin
            acc_d = wrap_angle(acc_q + d1_q);
        end
    end

    always_comb begin
        ovf_d = ovf_q | (bus.sta & sat_d);
        if (bus.clr) begin
            ovf_d = 1'b0;
        end
    end

    fix_to_single u_fix_to_single (
        .fix_i    ($unsigned(acc_q)),
        .single_o (theta_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            d1_q    <= '0;
            acc_q   <= '0;
            theta_q <= '0;
        end else begin
            v1_q   <= bus.sta;
            v2_q   <= v1_q;
            done_q <= v2_q;
            ovf_q  <= ovf_d;
            acc_q  <= acc_d;
            if (bus.sta) begin
                d1_q <= d1_d;
            end
            if (v2_q) begin
                theta_q <= theta_d;
            end
        end
    end

    assign bus.theta    = theta_q;
    assign bus.done_sig = done_q;
    assign bus.ovf      = ovf_q;

endmodule
